// File: rtl/line_engine_gen.sv
// line_engine_gen: Bresenham line rasteriser that writes one pixel per STEP
// cycle into a burst accumulator. It flushes a masked DDR burst (one af
// command and BURST_W wdf words) whenever the burst key {y, x/PPB} changes
// or when the endpoint has been drawn.
module line_engine_gen #(
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int PIX_W     = 32,
  parameter int DATA_W    = 128,
  parameter int BURST_W   = 2,
  parameter int ROW_SHIFT = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 LE_ready,
  input  logic [PIX_W-1:0]     LE_color,
  input  logic [X_W+Y_W-1:0]   LE_point,
  input  logic                 LE_color_valid,
  input  logic                 LE_x0_y0_valid,
  input  logic                 LE_x1_y1_valid,
  input  logic                 LE_trigger,
  input  logic [31:0]          LE_frame_base,
  input  logic                 af_full,
  input  logic                 wdf_full,
  output logic [30:0]          af_addr_din,
  output logic                 af_wr_en,
  output logic [DATA_W-1:0]    wdf_din,
  output logic [DATA_W/8-1:0]  wdf_mask_din,
  output logic                 wdf_wr_en
);

  localparam int PPW    = DATA_W / PIX_W;
  localparam int PPB    = PPW * BURST_W;
  localparam int PB_LOG = $clog2(PPB);
  localparam int CW     = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int MB     = DATA_W / 8;
  localparam int PB     = PIX_W / 8;
  localparam int WW     = (BURST_W > 1) ? $clog2(BURST_W) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(BURST_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP, S_FLUSH_A, S_FLUSH_B} state_t;

  state_t                state_q, state_d;
  logic [PIX_W-1:0]      color_q, color_d;
  logic [X_W-1:0]        x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_W-1:0]        y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic signed [CW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                  sxn_q, sxn_d, syn_q, syn_d;
  logic [PPB-1:0]        acc_q, acc_d;      // 1 = pixel of this burst is drawn
  logic                  last_q, last_d;    // pending burst holds the endpoint
  logic [WW-1:0]         word_q, word_d;
  logic [30:0]           addr_q, addr_d;

  // Setup arithmetic, widened so |x1-x0| and -|y1-y0| never overflow.
  logic signed [CW-1:0]  ddx, ddy, abs_dx, neg_dy;
  assign ddx    = $signed({{(CW-X_W){1'b0}}, x1_q}) - $signed({{(CW-X_W){1'b0}}, x0_q});
  assign ddy    = $signed({{(CW-Y_W){1'b0}}, y1_q}) - $signed({{(CW-Y_W){1'b0}}, y0_q});
  assign abs_dx = ddx[CW-1] ? -ddx : ddx;
  assign neg_dy = ddy[CW-1] ? ddy : -ddy;

  // One Bresenham step from the current pixel.
  logic signed [CW:0]    e2;
  logic                  step_x, step_y, at_end, key_change;
  logic [X_W-1:0]        x_nx, x_n;
  logic [Y_W-1:0]        y_nx, y_n;
  logic signed [CW-1:0]  err_nx;
  logic [PPB-1:0]        pix_bit;
  logic [30:0]           burst_addr;
  assign e2         = {err_q, 1'b0};
  assign step_x     = (e2 >= dy_q);
  assign step_y     = (e2 <= dx_q);
  assign x_nx       = sxn_q ? x_q - X_W'(1) : x_q + X_W'(1);
  assign y_nx       = syn_q ? y_q - Y_W'(1) : y_q + Y_W'(1);
  assign x_n        = step_x ? x_nx : x_q;
  assign y_n        = step_y ? y_nx : y_q;
  assign err_nx     = err_q + (step_x ? dy_q : {CW{1'b0}}) + (step_y ? dx_q : {CW{1'b0}});
  assign at_end     = (x_q == x1_q) && (y_q == y1_q);
  assign key_change = (y_n != y_q) || ((x_n >> PB_LOG) != (x_q >> PB_LOG));
  assign pix_bit    = PPB'(1) << x_q[PB_LOG-1:0];
  assign burst_addr = LE_frame_base[30:0] + (31'(y_q) << ROW_SHIFT) + (31'(x_q >> PB_LOG) << 2);

  // Bit 31 of the frame base lies outside the 31-bit address space.
  logic unused_base_msb;
  assign unused_base_msb = LE_frame_base[31];

  // State register and datapath registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      color_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      acc_q   <= '0;
      last_q  <= 1'b0;
      word_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic, register latches, Bresenham walk and FIFO strobes.
  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    err_d     = err_q;
    sxn_d     = sxn_q;
    syn_d     = syn_q;
    acc_d     = acc_q;
    last_d    = last_q;
    word_d    = word_q;
    addr_d    = addr_q;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LE_color_valid) color_d = LE_color;
        if (LE_x0_y0_valid) begin
          x0_d = LE_point[X_W+Y_W-1 -: X_W];
          y0_d = LE_point[Y_W-1:0];
        end
        if (LE_x1_y1_valid) begin
          x1_d = LE_point[X_W+Y_W-1 -: X_W];
          y1_d = LE_point[Y_W-1:0];
        end
        if (LE_trigger) state_d = S_SETUP;
      end
      S_SETUP: begin
        x_d     = x0_q;
        y_d     = y0_q;
        dx_d    = abs_dx;
        dy_d    = neg_dy;
        err_d   = abs_dx + neg_dy;
        sxn_d   = ddx[CW-1];
        syn_d   = ddy[CW-1];
        acc_d   = '0;
        last_d  = 1'b0;
        state_d = S_STEP;
      end
      S_STEP: begin
        acc_d = acc_q | pix_bit;
        if (at_end) begin
          last_d  = 1'b1;
          addr_d  = burst_addr;
          state_d = S_FLUSH_A;
        end else begin
          x_d   = x_n;
          y_d   = y_n;
          err_d = err_nx;
          // The address is taken from the pixel just drawn, before advancing.
          if (key_change) begin
            addr_d  = burst_addr;
            state_d = S_FLUSH_A;
          end
        end
      end
      S_FLUSH_A: begin
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          word_d    = WW'(1);
          if (BURST_W == 1) begin
            acc_d   = '0;
            state_d = last_q ? S_IDLE : S_STEP;
          end else begin
            state_d = S_FLUSH_B;
          end
        end
      end
      S_FLUSH_B: begin
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          if (word_q == LAST_WORD) begin
            acc_d   = '0;
            state_d = last_q ? S_IDLE : S_STEP;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output word: every lane carries the colour; undrawn pixels are masked.
  logic [WW-1:0]  word_sel;
  logic [PPW-1:0] word_pix;
  assign word_sel    = (state_q == S_FLUSH_B) ? word_q : '0;
  assign word_pix    = acc_q[word_sel*PPW +: PPW];
  assign LE_ready    = (state_q == S_IDLE);
  assign af_addr_din = addr_q;

  genvar gi;
  generate
    for (gi = 0; gi < PPW; gi++) begin : g_lane
      assign wdf_din[DATA_W-1-gi*PIX_W -: PIX_W] = color_q;
      assign wdf_mask_din[MB-1-gi*PB -: PB]      = {PB{~word_pix[gi]}};
    end
  endgenerate

endmodule
